// File: rtl/reram_column_readout_pkg.sv
// Shared types and helpers for the ReRAM column readout block.
//   readout_state_t : stream FSM state encoding
//   sat_sum_t       : result of a saturating accumulate (clipped sum + overflow flag)
//   sat_add()       : AW-bit saturating add, evaluated at AW+1 bits
package reram_readout_pkg;

    localparam int COLS_DEF      = 8;
    localparam int COL_WIDTH_DEF = 3;
    localparam int IW_DEF        = 8;
    localparam int AW_DEF        = 16;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } readout_state_t;

    typedef struct packed {
        logic              sat;
        logic [AW_DEF-1:0] sum;
    } sat_sum_t;

    // The carry out of the AW+1 bit sum is exactly the "exceeds 2^AW-1" condition.
    function automatic sat_sum_t sat_add(input logic [AW_DEF-1:0] a,
                                         input logic [AW_DEF-1:0] b);
        sat_sum_t        r;
        logic [AW_DEF:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        if (wide[AW_DEF]) begin
            r.sum = '1;
            r.sat = 1'b1;
        end else begin
            r.sum = wide[AW_DEF-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/reram_column_readout_if.sv
// Column-beat stream from the readout block to the neuron/ADC post-processing stage.
//   out_valid/out_ready : handshake, a beat transfers when both are high
//   out_data            : snapshot total of column out_col
//   out_col             : column index of the beat
//   out_last            : final column of the snapshot
//   out_sat             : that column clipped during integration
interface reram_column_readout_if #(
    parameter int AW        = 16,
    parameter int COL_WIDTH = 3
);
    logic                 out_valid;
    logic                 out_ready;
    logic [AW-1:0]        out_data;
    logic [COL_WIDTH-1:0] out_col;
    logic                 out_last;
    logic                 out_sat;

    modport master (
        output out_valid, out_data, out_col, out_last, out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_col, out_last, out_sat,
        output out_ready
    );
endinterface

// File: rtl/reram_column_readout_acc.sv
// One column's current integrator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_acc  : zero acc and sat (wins over apply_v)
//   apply_v    : add current this cycle
//   current    : unsigned column current sample
//   acc, sat   : running total (clipped at all-ones) and sticky clip flag
module column_accumulator
    import reram_readout_pkg::*;
#(
    parameter int IW = IW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_acc,
    input  logic              apply_v,
    input  logic [IW-1:0]     current,
    output logic [AW_DEF-1:0] acc,
    output logic              sat
);

    logic [AW_DEF-1:0] acc_reg, acc_next;
    logic              sat_reg, sat_next;
    sat_sum_t          add_res;

    always_comb begin
        add_res  = sat_add(acc_reg, {{(AW_DEF-IW){1'b0}}, current});
        acc_next = acc_reg;
        sat_next = sat_reg;
        if (clear_acc) begin
            acc_next = '0;
            sat_next = 1'b0;
        end else if (apply_v) begin
            acc_next = add_res.sum;
            // Once clipped, the column stays flagged until the next clear.
            sat_next = sat_reg | add_res.sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            sat_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            sat_reg <= sat_next;
        end
    end

    assign acc = acc_reg;
    assign sat = sat_reg;

endmodule

// File: rtl/reram_column_readout.sv
// Column-side readout: integrates per-column currents while rows are driven,
// snapshots every column on sample_i, then streams one column per beat.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_acc   : pulse, zero live accumulators and the overrun flag
//   apply_v     : level, integrate col_current each cycle
//   sample_i    : pulse, snapshot and start a stream (only honoured when idle)
//   col_current : packed currents, column c at [c*IW +: IW]
//   out_if      : beat stream (valid/ready, data, col, last, sat)
//   busy        : stream in progress
//   overrun     : sticky, a sample arrived while streaming
module reram_column_readout
    import reram_readout_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int COL_WIDTH = COL_WIDTH_DEF,
    parameter int IW        = IW_DEF,
    parameter int AW        = AW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_acc,
    input  logic                   apply_v,
    input  logic                   sample_i,
    input  logic [COLS*IW-1:0]     col_current,
    reram_column_readout_if.master out_if,
    output logic                   busy,
    output logic                   overrun
);

    logic [AW-1:0]        acc_arr [COLS];
    logic [COLS-1:0]      sat_arr;

    logic [AW-1:0]        snap_reg [COLS];
    logic [COLS-1:0]      snap_sat_reg;

    readout_state_t       state_reg, state_next;
    logic [COL_WIDTH-1:0] idx_reg, idx_next;
    logic                 overrun_reg, overrun_next;
    logic                 snap_load;
    logic                 streaming;
    logic                 last_beat;

    // Live integrators run independently of the stream FSM, so a new
    // integration can overlap the streaming of the previous snapshot.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            column_accumulator #(
                .IW (IW)
            ) u_acc (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear_acc (clear_acc),
                .apply_v   (apply_v),
                .current   (col_current[gi*IW +: IW]),
                .acc       (acc_arr[gi]),
                .sat       (sat_arr[gi])
            );
        end
    endgenerate

    assign streaming = (state_reg == S_STREAM);
    assign last_beat = (idx_reg == COL_WIDTH'(COLS-1));

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        snap_load    = 1'b0;
        overrun_next = overrun_reg;

        case (state_reg)
            S_IDLE: begin
                if (sample_i) begin
                    snap_load  = 1'b1;
                    idx_next   = '0;
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_if.out_ready) begin
                    if (last_beat) begin
                        state_next = S_IDLE;
                    end else begin
                        idx_next = idx_reg + COL_WIDTH'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A sample seen while streaming (including on the final accepted
        // beat) is dropped and flagged; clear_acc has priority.
        if (clear_acc) begin
            overrun_next = 1'b0;
        end else if (sample_i && streaming) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            idx_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            overrun_reg <= overrun_next;
        end
    end

    // Snapshot captures the register values, not this cycle's update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                snap_reg[c] <= '0;
            end
            snap_sat_reg <= '0;
        end else if (snap_load) begin
            for (int c = 0; c < COLS; c++) begin
                snap_reg[c] <= acc_arr[c];
            end
            snap_sat_reg <= sat_arr;
        end
    end

    // Beat outputs depend only on registers, never on out_ready, so they
    // stay put while a beat is stalled. Forced to zero when idle.
    assign out_if.out_valid = streaming;
    assign out_if.out_data  = streaming ? snap_reg[idx_reg] : '0;
    assign out_if.out_col   = streaming ? idx_reg : '0;
    assign out_if.out_last  = streaming & last_beat;
    assign out_if.out_sat   = streaming & snap_sat_reg[idx_reg];
    assign busy             = streaming;
    assign overrun          = overrun_reg;

endmodule
